qpsk_mapper: RTL and testbench

Baseband QPSK symbol mapper sitting directly downstream of the serial-to-parallel converter. Takes 2-bit dibits, Gray-decodes them to a quadrant phase (absolute or differential), maps the phase to signed I/Q constellation points, and zero-stuff upsamples to OSR samples per symbol for the pulse-shaping filter. A one-entry holding register absorbs bursty dibit arrival, and a sticky flag records overruns.

---
 rtl/qpsk_pkg.sv | 21 ++
 rtl/qpsk_point_lut.sv | 19 +
 rtl/qpsk_mapper.sv | 118 +++++++++++
 tb/tb_qpsk_mapper.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK mapper: phase type, FSM states,
// Gray-to-delta decode and per-quadrant sign masks.
package qpsk_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Bit n set means the axis is negative for phase n (I: +,-,-,+  Q: +,+,-,-).
    localparam logic [3:0] I_NEG_MASK = 4'b0110;
    localparam logic [3:0] Q_NEG_MASK = 4'b1100;

    // Gray decode: 00->0, 01->1, 11->2, 10->3.
    function automatic phase_t gray_to_delta(input logic [1:0] dibit);
        return {dibit[1], dibit[1] ^ dibit[0]};
    endfunction

endpackage

// File: rtl/qpsk_point_lut.sv
// Combinational quadrant-to-constellation lookup; shared with the 16-QAM mapper.
module qpsk_point_lut
    import qpsk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMP   = 90
) (
    input  phase_t                   phase_i,
    output logic signed [WIDTH-1:0]  i_o,
    output logic signed [WIDTH-1:0]  q_o
);

    localparam logic signed [WIDTH-1:0] POS = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] NEG = -POS;

    assign i_o = I_NEG_MASK[phase_i] ? NEG : POS;
    assign q_o = Q_NEG_MASK[phase_i] ? NEG : POS;

endmodule

// File: rtl/qpsk_mapper.sv
// QPSK mapper: Gray decode, absolute/differential phase, I/Q lookup and
// zero-stuff upsampling with a one-entry hold register and sticky overrun flag.
module qpsk_mapper
    import qpsk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMP   = 90,
    parameter int OSR   = 2,
    parameter int DIFF  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    din_valid,
    input  logic [1:0]              din,
    output logic signed [WIDTH-1:0] i_out,
    output logic signed [WIDTH-1:0] q_out,
    output logic                    dout_valid,
    output logic                    sym_start,
    output logic                    overflow
);

    localparam int                CNT_W    = $clog2(OSR);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OSR - 1);

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    phase_t                   phase_q;
    logic                     hold_valid_q;
    logic [1:0]               hold_q;
    logic signed [WIDTH-1:0]  i_q, q_q;
    logic                     dout_valid_q, sym_start_q, overflow_q;

    logic                     accept, at_boundary, start;
    logic [1:0]               sel_dibit;
    phase_t                   delta, phase_d;
    logic signed [WIDTH-1:0]  lut_i, lut_q;

    // NOTE: every always_comb output is assigned on every path, so no latch can form.
    always_comb begin
        accept      = en && din_valid;
        at_boundary = (state_q == IDLE) || (cnt_q == CNT_LAST);
        start       = at_boundary && (hold_valid_q || accept);
        sel_dibit   = hold_valid_q ? hold_q : din;
        delta       = gray_to_delta(sel_dibit);
        phase_d     = (DIFF != 0) ? phase_t'(phase_q + delta) : delta;
    end

    qpsk_point_lut #(
        .WIDTH (WIDTH),
        .AMP   (AMP)
    ) u_point_lut (
        .phase_i (phase_d),
        .i_o     (lut_i),
        .q_o     (lut_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            phase_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            i_q          <= '0;
            q_q          <= '0;
            dout_valid_q <= 1'b0;
            sym_start_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (!en) begin
            dout_valid_q <= 1'b0;
            sym_start_q  <= 1'b0;
        end else begin
            // Hold register: refill behind a consumed entry, else capture or overrun.
            if (start && hold_valid_q) begin
                hold_valid_q <= accept;
                if (accept) hold_q <= din;
            end else if (!start && accept) begin
                if (!hold_valid_q) begin
                    hold_valid_q <= 1'b1;
                    hold_q       <= din;
                end else begin
                    overflow_q   <= 1'b1;
                end
            end

            if (start) begin
                state_q      <= EMIT;
                cnt_q        <= '0;
                phase_q      <= phase_d;
                i_q          <= lut_i;
                q_q          <= lut_q;
                dout_valid_q <= 1'b1;
                sym_start_q  <= 1'b1;
            end else if (at_boundary) begin
                state_q      <= IDLE;
                i_q          <= '0;
                q_q          <= '0;
                dout_valid_q <= 1'b0;
                sym_start_q  <= 1'b0;
            end else begin
                cnt_q        <= cnt_q + CNT_W'(1);
                i_q          <= '0;
                q_q          <= '0;
                dout_valid_q <= 1'b1;
                sym_start_q  <= 1'b0;
            end
        end
    end

    assign i_out      = i_q;
    assign q_out      = q_q;
    assign dout_valid = dout_valid_q;
    assign sym_start  = sym_start_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper: three instances (absolute OSR=2,
// differential OSR=2, absolute OSR=4) share stimulus; each test checks one.
module tb_qpsk_mapper;

    logic       clk = 1'b0;
    logic       reset, en, din_valid;
    logic [1:0] din;

    logic signed [7:0] a_i, a_q, d_i, d_q, b_i, b_q;
    logic              a_v, a_s, a_o, d_v, d_s, d_o, b_v, b_s, b_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qpsk_mapper #(.WIDTH(8), .AMP(90), .OSR(2), .DIFF(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
        .i_out(a_i), .q_out(a_q), .dout_valid(a_v), .sym_start(a_s), .overflow(a_o));

    qpsk_mapper #(.WIDTH(8), .AMP(90), .OSR(2), .DIFF(1)) dut_d (
        .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
        .i_out(d_i), .q_out(d_q), .dout_valid(d_v), .sym_start(d_s), .overflow(d_o));

    qpsk_mapper #(.WIDTH(8), .AMP(90), .OSR(4), .DIFF(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
        .i_out(b_i), .q_out(b_q), .dout_valid(b_v), .sym_start(b_s), .overflow(b_o));

    task automatic apply_reset();
        reset     = 1'b0;
        en        = 1'b1;
        din_valid = 1'b0;
        din       = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({a_i, a_q, a_v, a_s, a_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_a got i=%0d q=%0d v=%b s=%b o=%b want all 0", a_i, a_q, a_v, a_s, a_o);
        end
        checks++;
        if ({d_i, d_q, d_v, d_s, d_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_d got i=%0d q=%0d v=%b s=%b o=%b want all 0", d_i, d_q, d_v, d_s, d_o);
        end
        checks++;
        if ({b_i, b_q, b_v, b_s, b_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_b got i=%0d q=%0d v=%b s=%b o=%b want all 0", b_i, b_q, b_v, b_s, b_o);
        end
    endtask

    task automatic test_absolute();
        logic [1:0] dib [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        int ei [8] = '{90, 0, -90, 0, -90, 0, 90, 0};
        int eq [8] = '{90, 0, 90, 0, -90, 0, -90, 0};
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            din_valid = (k % 2 == 0);
            din       = dib[k / 2];
            @(negedge clk);
            checks++;
            if (int'(a_i) !== ei[k] || int'(a_q) !== eq[k] || a_v !== 1'b1 || a_s !== (k % 2 == 0)) begin
                failures++;
                $display("FAIL absolute[%0d] got i=%0d q=%0d v=%b s=%b want i=%0d q=%0d v=1 s=%b",
                         k, a_i, a_q, a_v, a_s, ei[k], eq[k], (k % 2 == 0));
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_differential();
        logic [1:0] dib [5] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10};
        int pi [5] = '{-90, -90, 90, 90, 90};
        int pq [5] = '{90, -90, 90, 90, -90};
        int ei, eq;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            din_valid = (k % 2 == 0);
            din       = dib[k / 2];
            @(negedge clk);
            ei = (k % 2 == 0) ? pi[k / 2] : 0;
            eq = (k % 2 == 0) ? pq[k / 2] : 0;
            checks++;
            if (int'(d_i) !== ei || int'(d_q) !== eq || d_v !== 1'b1 || d_s !== (k % 2 == 0)) begin
                failures++;
                $display("FAIL differential[%0d] got i=%0d q=%0d v=%b s=%b want i=%0d q=%0d v=1 s=%b",
                         k, d_i, d_q, d_v, d_s, ei, eq, (k % 2 == 0));
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_hold_overrun();
        logic [1:0] dib [3] = '{2'b00, 2'b11, 2'b01};
        int ei [9] = '{90, 0, 0, 0, -90, 0, 0, 0, 0};
        int eq [9] = '{90, 0, 0, 0, -90, 0, 0, 0, 0};
        logic ev, es, eo;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            din_valid = (k < 3);
            din       = (k < 3) ? dib[k] : 2'b00;
            @(negedge clk);
            ev = (k < 8);
            es = (k == 0 || k == 4);
            eo = (k >= 2);
            checks++;
            if (int'(b_i) !== ei[k] || int'(b_q) !== eq[k] || b_v !== ev || b_s !== es || b_o !== eo) begin
                failures++;
                $display("FAIL hold_overrun[%0d] got i=%0d q=%0d v=%b s=%b o=%b want i=%0d q=%0d v=%b s=%b o=%b",
                         k, b_i, b_q, b_v, b_s, b_o, ei[k], eq[k], ev, es, eo);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_idle_gap();
        int ei [9] = '{90, 0, 0, 0, 0, 0, 0, -90, 0};
        int eq [9] = '{-90, 0, 0, 0, 0, 0, 0, 90, 0};
        logic ev, es;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            din_valid = (k == 0 || k == 7);
            din       = (k == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            ev = (k < 2 || k >= 7);
            es = (k == 0 || k == 7);
            checks++;
            if (int'(a_i) !== ei[k] || int'(a_q) !== eq[k] || a_v !== ev || a_s !== es) begin
                failures++;
                $display("FAIL idle_gap[%0d] got i=%0d q=%0d v=%b s=%b want i=%0d q=%0d v=%b s=%b",
                         k, a_i, a_q, a_v, a_s, ei[k], eq[k], ev, es);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_en_pause();
        int   ei;
        logic ev, es;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            en        = !(k >= 2 && k <= 4);
            din_valid = (k == 0) || (k >= 2 && k <= 4);
            din       = (k == 0) ? 2'b00 : 2'b11;
            @(negedge clk);
            ei = (k == 0) ? 90 : 0;
            ev = (k <= 1) || (k == 5) || (k == 6);
            es = (k == 0);
            checks++;
            if (int'(b_i) !== ei || int'(b_q) !== ei || b_v !== ev || b_s !== es || b_o !== 1'b0) begin
                failures++;
                $display("FAIL en_pause[%0d] got i=%0d q=%0d v=%b s=%b o=%b want i=%0d q=%0d v=%b s=%b o=0",
                         k, b_i, b_q, b_v, b_s, b_o, ei, ei, ev, es);
            end
        end
        en        = 1'b1;
        din_valid = 1'b0;
    endtask

    task automatic test_reset_mid_symbol();
        logic [1:0] dib [4] = '{2'b01, 2'b01, 2'b11, 2'b00};
        int ei [4] = '{-90, 0, -90, 0};
        int eq [4] = '{90, 0, -90, 0};
        logic es, eo;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            din_valid = 1'b1;
            din       = dib[k];
            @(negedge clk);
            es = (k % 2 == 0);
            eo = (k == 3);
            checks++;
            if (int'(d_i) !== ei[k] || int'(d_q) !== eq[k] || d_v !== 1'b1 || d_s !== es || d_o !== eo) begin
                failures++;
                $display("FAIL pre_reset[%0d] got i=%0d q=%0d v=%b s=%b o=%b want i=%0d q=%0d v=1 s=%b o=%b",
                         k, d_i, d_q, d_v, d_s, d_o, ei[k], eq[k], es, eo);
            end
        end
        din_valid = 1'b0;
        reset     = 1'b0;
        #1;
        checks++;
        if ({d_i, d_q, d_v, d_s, d_o} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset got i=%0d q=%0d v=%b s=%b o=%b want all 0", d_i, d_q, d_v, d_s, d_o);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din_valid = (k == 0);
            din       = 2'b01;
            @(negedge clk);
            checks++;
            if (int'(d_i) !== ((k == 0) ? -90 : 0) || int'(d_q) !== ((k == 0) ? 90 : 0) ||
                d_v !== (k < 2) || d_s !== (k == 0) || d_o !== 1'b0) begin
                failures++;
                $display("FAIL post_reset[%0d] got i=%0d q=%0d v=%b s=%b o=%b want i=%0d q=%0d v=%b s=%b o=0",
                         k, d_i, d_q, d_v, d_s, d_o, (k == 0) ? -90 : 0, (k == 0) ? 90 : 0, (k < 2), (k == 0));
            end
        end
        din_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_absolute();
        test_differential();
        test_hold_overrun();
        test_idle_gap();
        test_en_pause();
        test_reset_mid_symbol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
